// File: rtl/field_iterator_pkg.sv
// field_iterator_pkg: shared types and sizing helpers for the field iterator.
//   field_desc_t - one descriptor-table entry {bit offset, field width}
//   state_t      - walker FSM state
// Descriptor fields have a fixed, generous width so the struct can live in
// the package. Modules narrow the stored values to their own parameter sizes.
package field_iterator_pkg;

    localparam int DESC_FLD_W = 16;

    typedef struct packed {
        logic [DESC_FLD_W-1:0] offset;
        logic [DESC_FLD_W-1:0] width;
    } field_desc_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    // Index width that never collapses to zero bits
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/field_extract.sv
// field_extract: combinational shift / mask / clamp of one field out of an
// object.
//   obj    - packed object; bits at or above OBJ_W read as zero
//   offset - bit offset of the field LSB
//   width  - field width; 0 gives 0, values above FIELD_W clamp to FIELD_W
//   value  - extracted field, zero-extended to FIELD_W
module field_extract
    import field_iterator_pkg::*;
#(
    parameter int OBJ_W   = 64,
    parameter int FIELD_W = 32
) (
    input  logic [OBJ_W-1:0]           obj,
    input  logic [$clog2(OBJ_W)-1:0]   offset,
    input  logic [$clog2(FIELD_W):0]   width,
    output logic [FIELD_W-1:0]         value
);

    localparam int WID_W = $clog2(FIELD_W) + 1;
    localparam int EXT_W = (OBJ_W > FIELD_W) ? OBJ_W : FIELD_W;
    localparam int MSK_W = FIELD_W + 1;

    logic [EXT_W-1:0] shifted;
    logic [WID_W-1:0] eff_w;
    logic [MSK_W-1:0] mask;

    // The logical shift fills with zeros, so a field running off the top of
    // the object keeps only its in-range bits.
    assign shifted = EXT_W'(obj) >> offset;
    assign eff_w   = (width > WID_W'(FIELD_W)) ? WID_W'(FIELD_W) : width;
    // The extra mask bit lets a full-width field produce an all-ones mask.
    assign mask    = (MSK_W'(1) << eff_w) - MSK_W'(1);
    assign value   = shifted[FIELD_W-1:0] & mask[FIELD_W-1:0];

endmodule

// File: rtl/field_iterator.sv
// field_iterator: walks a captured object through a programmable descriptor
// table, emitting one field per accepted output beat.
//   clk, rst                      - clock, synchronous active-high reset
//   cfg_we/cfg_idx/cfg_offset/cfg_width - descriptor write (IDLE only)
//   cfg_count_we/cfg_count        - active field count write (IDLE only,
//                                   saturates at MAX_FIELDS)
//   cfg_busy                      - walk in progress
//   in_valid/in_ready/in_obj      - object input handshake
//   out_valid/out_ready/out_idx/out_value/out_last - field stream
//   done                          - one-cycle pulse after an object is walked
module field_iterator
    import field_iterator_pkg::*;
#(
    parameter int OBJ_W      = 64,
    parameter int MAX_FIELDS = 8,
    parameter int FIELD_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(MAX_FIELDS)-1:0] cfg_idx,
    input  logic [$clog2(OBJ_W)-1:0]      cfg_offset,
    input  logic [$clog2(FIELD_W):0]      cfg_width,
    input  logic                          cfg_count_we,
    input  logic [$clog2(MAX_FIELDS):0]   cfg_count,
    output logic                          cfg_busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OBJ_W-1:0]              in_obj,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(MAX_FIELDS)-1:0] out_idx,
    output logic [FIELD_W-1:0]            out_value,
    output logic                          out_last,
    output logic                          done
);

    localparam int IDX_W = $clog2(MAX_FIELDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(OBJ_W);
    localparam int WID_W = $clog2(FIELD_W) + 1;

    state_t             state;
    field_desc_t        desc [MAX_FIELDS];
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   idx;
    logic [OBJ_W-1:0]   obj;
    logic [CNT_W-1:0]   cnt_wr;
    logic [CNT_W-1:0]   cnt_eff;
    logic [FIELD_W-1:0] ext_value;
    logic               walk;
    logic               last;

    assign walk = (state == WALK);

    // A count written alongside an accepted object governs that object's walk.
    assign cnt_wr  = (cfg_count > CNT_W'(MAX_FIELDS)) ? CNT_W'(MAX_FIELDS) : cfg_count;
    assign cnt_eff = cfg_count_we ? cnt_wr : count;

    // count is never zero in WALK, so count-1 cannot wrap when it matters.
    assign last = ({1'b0, idx} == (count - CNT_W'(1)));

    field_extract #(
        .OBJ_W   (OBJ_W),
        .FIELD_W (FIELD_W)
    ) u_extract (
        .obj    (obj),
        .offset (desc[idx].offset[OFF_W-1:0]),
        .width  (desc[idx].width[WID_W-1:0]),
        .value  (ext_value)
    );

    assign cfg_busy  = walk;
    assign in_ready  = !walk;
    assign out_valid = walk;
    assign out_idx   = walk ? idx : '0;
    assign out_value = walk ? ext_value : '0;
    assign out_last  = walk && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            obj   <= '0;
            count <= '0;
            done  <= 1'b0;
            for (int i = 0; i < MAX_FIELDS; i++) begin
                desc[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we && (int'(cfg_idx) < MAX_FIELDS)) begin
                        desc[cfg_idx].offset <= DESC_FLD_W'(cfg_offset);
                        desc[cfg_idx].width  <= DESC_FLD_W'(cfg_width);
                    end
                    if (cfg_count_we) begin
                        count <= cnt_wr;
                    end
                    if (in_valid) begin
                        obj <= in_obj;
                        idx <= '0;
                        if (cnt_eff != '0) begin
                            state <= WALK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WALK: begin
                    // Table and count are frozen here; cfg writes are dropped.
                    if (out_ready) begin
                        if (last) begin
                            state <= IDLE;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_field_iterator.sv
module tb_field_iterator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [5:0]  cfg_offset;
    logic [5:0]  cfg_width;
    logic        cfg_count_we;
    logic [3:0]  cfg_count;
    logic        cfg_busy;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_obj;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx;
    logic [31:0] out_value;
    logic        out_last;
    logic        done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]  off;
        logic [5:0]  wid;
        logic [63:0] obj;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    field_iterator #(.OBJ_W(64), .MAX_FIELDS(8), .FIELD_W(32)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_offset(cfg_offset), .cfg_width(cfg_width),
        .cfg_count_we(cfg_count_we), .cfg_count(cfg_count), .cfg_busy(cfg_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_obj(in_obj),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_value(out_value), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_desc(input int i, input int off, input int wid);
        cfg_we = 1'b1; cfg_idx = 3'(i); cfg_offset = 6'(off); cfg_width = 6'(wid);
        step;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_cnt(input int n);
        cfg_count_we = 1'b1; cfg_count = 4'(n);
        step;
        cfg_count_we = 1'b0;
    endtask

    task automatic offer(input logic [63:0] o);
        in_valid = 1'b1; in_obj = o;
        step;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_offset = 0; cfg_width = 0;
        cfg_count_we = 0; cfg_count = 0; in_valid = 0; in_obj = '0; out_ready = 1'b1;

        vecs[0] = '{6'd0,  6'd8,  64'h0000_0000_00AB_CDEF, 32'h0000_00EF};
        vecs[1] = '{6'd8,  6'd16, 64'h0000_0000_00AB_CDEF, 32'h0000_ABCD};
        vecs[2] = '{6'd60, 6'd8,  64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_000F};
        vecs[3] = '{6'd0,  6'd40, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{6'd4,  6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{6'd32, 6'd32, 64'h1234_5678_9ABC_DEF0, 32'h1234_5678};
        vecs[6] = '{6'd63, 6'd32, 64'h8000_0000_0000_0000, 32'h0000_0001};
        vecs[7] = '{6'd12, 6'd12, 64'h0000_0000_00AB_CDEF, 32'h0000_0ABC};
        vecs[8] = '{6'd1,  6'd32, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF};
        vecs[9] = '{6'd3,  6'd5,  64'h0000_0000_0000_00F0, 32'h0000_001E};

        step; step;
        rst = 1'b0;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_last",  64'(out_last),  64'd0);
        check("reset out_idx",   64'(out_idx),   64'd0);
        check("reset out_value", 64'(out_value), 64'd0);
        check("reset done",      64'(done),      64'd0);
        check("reset cfg_busy",  64'(cfg_busy),  64'd0);
        check("reset in_ready",  64'(in_ready),  64'd1);

        // Single-field table vectors
        cfg_cnt(1);
        for (int v = 0; v < 10; v++) begin
            cfg_desc(0, int'(vecs[v].off), int'(vecs[v].wid));
            offer(vecs[v].obj);
            check($sformatf("vec%0d value", v), 64'(out_value), 64'(vecs[v].exp));
            check($sformatf("vec%0d last", v),  64'(out_last),  64'd1);
            step;
            check($sformatf("vec%0d done", v),  64'(done),      64'd1);
        end

        // Two-field walk, continuous ready: done count+1 cycles after handshake
        cfg_desc(0, 0, 8); cfg_desc(1, 8, 16); cfg_cnt(2);
        offer(64'h0000_0000_00AB_CDEF);
        check("c1 valid",  64'(out_valid), 64'd1);
        check("c1 idx",    64'(out_idx),   64'd0);
        check("c1 value",  64'(out_value), 64'hEF);
        check("c1 last",   64'(out_last),  64'd0);
        check("c1 busy",   64'(cfg_busy),  64'd1);
        check("c1 ready",  64'(in_ready),  64'd0);
        step;
        check("c2 idx",    64'(out_idx),   64'd1);
        check("c2 value",  64'(out_value), 64'hABCD);
        check("c2 last",   64'(out_last),  64'd1);
        check("c2 done",   64'(done),      64'd0);
        step;
        check("c3 done",   64'(done),      64'd1);
        check("c3 valid",  64'(out_valid), 64'd0);
        step;
        check("c4 done",   64'(done),      64'd0);

        // Backpressure on idx0 for 4 cycles; in_obj wiggles meanwhile
        out_ready = 1'b0;
        offer(64'h0000_0000_00AB_CDEF);
        for (int k = 0; k < 4; k++) begin
            in_obj = 64'($urandom) << 8;
            check($sformatf("bp%0d value", k), 64'(out_value), 64'hEF);
            check($sformatf("bp%0d idx", k),   64'(out_idx),   64'd0);
            check($sformatf("bp%0d valid", k), 64'(out_valid), 64'd1);
            if (k == 3) out_ready = 1'b1;
            step;
        end
        check("bp idx1",   64'(out_idx),   64'd1);
        check("bp value1", 64'(out_value), 64'hABCD);
        check("bp last1",  64'(out_last),  64'd1);
        step;
        check("bp done",   64'(done),      64'd1);

        // cfg writes during WALK are dropped
        out_ready = 1'b0;
        offer(64'h0000_0000_00AB_CDEF);
        cfg_we = 1'b1; cfg_idx = 0; cfg_offset = 6'd16; cfg_width = 6'd8;
        cfg_count_we = 1'b1; cfg_count = 4'd1;
        step;
        cfg_we = 1'b0; cfg_count_we = 1'b0;
        check("busy wr value0", 64'(out_value), 64'hEF);
        check("busy wr last0",  64'(out_last),  64'd0);
        out_ready = 1'b1;
        step;
        check("busy wr value1", 64'(out_value), 64'hABCD);
        check("busy wr last1",  64'(out_last),  64'd1);
        step;
        check("busy wr done",   64'(done),      64'd1);
        cfg_desc(0, 16, 8);
        offer(64'h0000_0000_00AB_CDEF);
        check("idle wr value0", 64'(out_value), 64'hAB);
        step; step;

        // cfg write in the same cycle as the accepted object applies
        in_valid = 1'b1; in_obj = 64'h0000_0000_00AB_CDEF;
        cfg_we = 1'b1; cfg_idx = 0; cfg_offset = 6'd4; cfg_width = 6'd8;
        cfg_count_we = 1'b1; cfg_count = 4'd1;
        step;
        in_valid = 1'b0; cfg_we = 1'b0; cfg_count_we = 1'b0;
        check("same-cyc value", 64'(out_value), 64'hDE);
        check("same-cyc last",  64'(out_last),  64'd1);
        step;
        check("same-cyc done",  64'(done),      64'd1);

        // Count saturates to MAX_FIELDS: byte walk over all 8 descriptors
        for (int i = 0; i < 8; i++) cfg_desc(i, 8 * i, 8);
        cfg_cnt(15);
        offer(64'h8877_6655_4433_2211);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sat idx%0d", i),   64'(out_idx),   64'(i));
            check($sformatf("sat value%0d", i), 64'(out_value), 64'(8'h11 * (i + 1)));
            check($sformatf("sat last%0d", i),  64'(out_last),  64'(i == 7));
            step;
        end
        check("sat done", 64'(done), 64'd1);

        // Count = 0: object consumed, single done, no output
        cfg_cnt(0);
        in_valid = 1'b1; in_obj = 64'h1;
        check("cnt0 in_ready", 64'(in_ready), 64'd1);
        step;
        in_valid = 1'b0;
        check("cnt0 valid", 64'(out_valid), 64'd0);
        check("cnt0 done",  64'(done),      64'd1);
        check("cnt0 ready", 64'(in_ready),  64'd1);
        step;
        check("cnt0 done2", 64'(done),      64'd0);

        // Reset on idx1 of a 4-field walk
        cfg_cnt(4);
        offer(64'h8877_6655_4433_2211);
        step;
        check("rst idx1", 64'(out_idx), 64'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("rst valid", 64'(out_valid), 64'd0);
        check("rst busy",  64'(cfg_busy),  64'd0);
        check("rst done",  64'(done),      64'd0);
        check("rst ready", 64'(in_ready),  64'd1);
        step;
        check("rst done2", 64'(done),      64'd0);
        check("rst valid2", 64'(out_valid), 64'd0);
        // count reset to 0: a new object completes with no output
        offer(64'h5);
        check("rst cnt0 valid", 64'(out_valid), 64'd0);
        check("rst cnt0 done",  64'(done),      64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
